// File: rtl/ann_controller.sv
// Sequencer for the two-layer ANN datapath: walks groups x input chunks per layer,
// pulses neuron clear/start, waits on the finish handshake and loads result registers.
module ann_controller #(
  parameter int L0_GROUPS = 4,
  parameter int L0_LEVELS = 8,
  parameter int L1_GROUPS = 2,
  parameter int L1_LEVELS = 4,
  localparam int GP_W = (L0_GROUPS > 1) ? $clog2(L0_GROUPS) : 1,
  localparam int LV_W = (L0_LEVELS > 1) ? $clog2(L0_LEVELS) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 finish_i,
  output logic                 neu_start_o,
  output logic                 neu_rst_o,
  output logic [GP_W-1:0]      gp_o,
  output logic                 layer_o,
  output logic [LV_W-1:0]      level_o,
  output logic [L0_GROUPS-1:0] ld_o,
  output logic [L1_GROUPS-1:0] ld_ans_o,
  output logic                 busy_o,
  output logic                 done_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_FETCH, S_RUN, S_WAIT, S_STORE, S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [GP_W-1:0]   gp_q, gp_d;
  logic              layer_q, layer_d;
  logic [LV_W-1:0]   level_q, level_d;
  logic [GP_W-1:0]   last_gp;
  logic [LV_W-1:0]   last_lv;

  assign last_gp = layer_q ? GP_W'(L1_GROUPS - 1) : GP_W'(L0_GROUPS - 1);
  assign last_lv = layer_q ? LV_W'(L1_LEVELS - 1) : LV_W'(L0_LEVELS - 1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      gp_q    <= '0;
      layer_q <= 1'b0;
      level_q <= '0;
    end else begin
      state_q <= state_d;
      gp_q    <= gp_d;
      layer_q <= layer_d;
      level_q <= level_d;
    end
  end

  // Selects only move on IDLE->CLR, WAIT->FETCH, STORE->CLR and DONE->IDLE,
  // so they stay stable across the whole group they address.
  always_comb begin
    state_d = state_q;
    gp_d    = gp_q;
    layer_d = layer_q;
    level_d = level_q;
    case (state_q)
      S_IDLE: if (start_i) begin
        state_d = S_CLR;
        gp_d    = '0;
        layer_d = 1'b0;
        level_d = '0;
      end
      S_CLR:   state_d = S_FETCH;
      S_FETCH: state_d = S_RUN;
      S_RUN:   state_d = S_WAIT;
      S_WAIT: if (finish_i) begin
        if (level_q != last_lv) begin
          level_d = level_q + 1'b1;
          state_d = S_FETCH;
        end else begin
          state_d = S_STORE;
        end
      end
      S_STORE: begin
        if (gp_q != last_gp) begin
          gp_d    = gp_q + 1'b1;
          level_d = '0;
          state_d = S_CLR;
        end else if (!layer_q) begin
          layer_d = 1'b1;
          gp_d    = '0;
          level_d = '0;
          state_d = S_CLR;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        gp_d    = '0;
        layer_d = 1'b0;
        level_d = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    neu_rst_o   = (state_q == S_CLR);
    neu_start_o = (state_q == S_RUN);
    busy_o      = (state_q != S_IDLE);
    done_o      = (state_q == S_DONE);
    ld_o        = '0;
    ld_ans_o    = '0;
    for (int i = 0; i < L0_GROUPS; i++)
      ld_o[i] = (state_q == S_STORE) && !layer_q && (gp_q == GP_W'(i));
    for (int i = 0; i < L1_GROUPS; i++)
      ld_ans_o[i] = (state_q == S_STORE) && layer_q && (gp_q == GP_W'(i));
  end

  assign gp_o    = gp_q;
  assign layer_o = layer_q;
  assign level_o = level_q;

endmodule

// File: tb/tb_ann_controller.sv
// Scoreboard bench for ann_controller: a loop-level model of the inference schedule
// predicts every pulse and its cycle offset; a monitor pops and compares.
module tb_ann_controller;

  logic       clk = 1'b0;
  logic       rst, start_drv, start_noise, start;
  logic       fin_resp, fin_noise, fin_tie, finish;
  logic       neu_start, neu_rst, layer, busy, done;
  logic [1:0] gp, ld_ans;
  logic [2:0] level;
  logic [3:0] ld;

  assign start  = start_drv | start_noise;
  assign finish = fin_resp | fin_noise | fin_tie;

  ann_controller dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .finish_i(finish),
    .neu_start_o(neu_start), .neu_rst_o(neu_rst), .gp_o(gp), .layer_o(layer),
    .level_o(level), .ld_o(ld), .ld_ans_o(ld_ans), .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;

  typedef struct { int kind; int val; int off; } ev_t;
  ev_t expq[$];
  int  fdel[64];
  bit  fetch_mark[1024];
  int  cyc = 0, base = 0, fidx = 0, cnt = 0;
  int  pass_cnt = 0, chk_cnt = 0;
  int  n_st = 0, n_rst = 0, done_off = -1, t_l1 = 0, model_end = 0;
  bit  noise_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic void push(input int kind, input int val, input int off, input int cut);
    ev_t e;
    e.kind = kind; e.val = val; e.off = off;
    if (off <= cut) expq.push_back(e);
  endfunction

  // Walk the schedule: CLR, then per chunk FETCH+RUN+F wait cycles, then STORE; DONE at end.
  task automatic build(input int cut);
    int cur, k;
    cur = 0; k = 0;
    for (int i = 0; i < 1024; i++) fetch_mark[i] = 1'b0;
    for (int ly = 0; ly < 2; ly++) begin
      int ng, nl;
      ng = ly ? 2 : 4;
      nl = ly ? 4 : 8;
      for (int g = 0; g < ng; g++) begin
        cur++;
        push(0, ly*64 + g*8, cur, cut);
        for (int l = 0; l < nl; l++) begin
          cur++;
          fetch_mark[cur] = 1'b1;
          cur++;
          if (ly == 1 && g == 0 && l == 0) t_l1 = cur;
          push(1, ly*64 + g*8 + l, cur, cut);
          cur += fdel[k];
          k++;
        end
        cur++;
        push(ly ? 3 : 2, 1 << g, cur, cut);
      end
    end
    cur++;
    push(4, 0, cur, cut);
    model_end = cur;
  endtask

  // Monitor: every visible pulse must match the head of the expected queue.
  always @(negedge clk) begin
    ev_t a, e;
    if (neu_rst || neu_start || ld != 0 || ld_ans != 0 || done) begin
      a.off = cyc - base;
      a.val = 0;
      if (neu_rst)          begin a.kind = 0; a.val = int'(layer)*64 + int'(gp)*8 + int'(level); end
      else if (neu_start)   begin a.kind = 1; a.val = int'(layer)*64 + int'(gp)*8 + int'(level); end
      else if (ld != 0)     begin a.kind = 2; a.val = int'(ld); end
      else if (ld_ans != 0) begin a.kind = 3; a.val = int'(ld_ans); end
      else                  a.kind = 4;
      if (neu_start) n_st++;
      if (neu_rst)   n_rst++;
      if (done)      done_off = a.off;
      check("start_rst_exclusive", int'(neu_start && neu_rst), 0);
      chk_cnt++;
      if (expq.size() == 0) begin
        $display("FAIL unexpected_event: kind %0d val %0d off %0d, none expected", a.kind, a.val, a.off);
      end else begin
        e = expq.pop_front();
        if (a.kind == e.kind && a.val == e.val && a.off == e.off) pass_cnt++;
        else $display("FAIL event: got kind %0d val %0d off %0d, expected kind %0d val %0d off %0d",
                      a.kind, a.val, a.off, e.kind, e.val, e.off);
      end
    end
  end

  // Finish responder: one-cycle finish pulse fdel[n] cycles after the n-th neu_start.
  always @(negedge clk) begin
    fin_resp = 1'b0;
    if (rst) cnt = 0;
    else begin
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) fin_resp = 1'b1;
      end
      if (neu_start) begin
        cnt = fdel[fidx % 64];
        fidx++;
      end
    end
  end

  // Disturbance: stray finish during FETCH and stray start pulses while busy.
  always @(posedge clk) begin
    int off;
    #1;
    off = cyc - base;
    fin_noise   = 1'b0;
    start_noise = 1'b0;
    if (noise_en && off >= 0 && off < 1024) begin
      fin_noise   = fetch_mark[off] && ($urandom_range(0, 1) == 1);
      start_noise = (off >= 3 && off <= 200 && (off % 23) == 0);
    end
  end

  task automatic kick();
    @(posedge clk); #1;
    base = cyc; fidx = 0; cnt = 0; n_st = 0; n_rst = 0; done_off = -1;
    start_drv = 1'b1;
    @(posedge clk); #1;
    start_drv = 1'b0;
  endtask

  task automatic drain(input int bound);
    int n;
    n = 0;
    while (expq.size() != 0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    check("drain_queue_empty", expq.size(), 0);
    expq.delete();
  endtask

  task automatic full_run(input string tag, input int exp_done);
    build(100000);
    kick();
    drain(2000);
    check({tag, "_done_cycle"}, done_off, exp_done);
    check({tag, "_neu_start_cnt"}, n_st, 40);
    check({tag, "_neu_rst_cnt"}, n_rst, 6);
    check({tag, "_busy_after"}, int'(busy), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cut;
    rst = 1'b1; start_drv = 1'b0; fin_tie = 1'b0;
    fin_resp = 1'b0; fin_noise = 1'b0; start_noise = 1'b0;
    for (int i = 0; i < 64; i++) fdel[i] = 3;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_gp", int'(gp), 0);
    check("rst_layer", int'(layer), 0);
    check("rst_level", int'(level), 0);
    check("rst_ld", int'(ld), 0);
    check("rst_ld_ans", int'(ld_ans), 0);
    check("rst_pulses", int'(neu_start) + int'(neu_rst) + int'(done), 0);
    check("rst_busy", int'(busy), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("idle_busy", int'(busy), 0);
    check("idle_sel", int'(gp) + int'(layer) + int'(level), 0);

    // Baseline: finish 3 cycles after each neu_start.
    full_run("base_f3", 213);

    // Finish tied high: each WAIT lasts exactly one cycle.
    for (int i = 0; i < 64; i++) fdel[i] = 1;
    @(posedge clk); #1; fin_tie = 1'b1;
    full_run("tied", 133);
    @(posedge clk); #1; fin_tie = 1'b0;

    // Random finish latency per chunk.
    for (int i = 0; i < 64; i++) fdel[i] = int'($urandom_range(1, 5));
    build(100000);
    cut = model_end;
    expq.delete();
    full_run("rand", cut);

    // Stray start and FETCH-time finish must not perturb the baseline.
    for (int i = 0; i < 64; i++) fdel[i] = 3;
    noise_en = 1'b1;
    full_run("noise", 213);
    noise_en = 1'b0;

    // Abort with rst in the first layer-1 WAIT: no answer loads, then clean restart.
    for (int i = 0; i < 64; i++) fdel[i] = 2;
    build(100000);
    expq.delete();
    cut = t_l1 + 1;
    build(cut);
    kick();
    while ((cyc - base) < cut && (cyc - base) < 2000) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_busy", int'(busy), 0);
    check("abort_sel", int'(gp) + int'(layer) + int'(level), 0);
    check("abort_ld_ans", int'(ld_ans), 0);
    check("abort_pre_events", expq.size(), 0);
    expq.delete();
    repeat (3) @(negedge clk);
    for (int i = 0; i < 64; i++) fdel[i] = 3;
    full_run("restart", 213);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
